// File: rtl/spi_register_controller.sv
`default_nettype none
// ============================================================================
// Module      : spi_register_controller
// Description : SPI mode-0 slave front end. Frames bytes from pre-synchronized
//               SPI lines, decodes a command byte (bit 7 = write, bits 6:0 =
//               start address) and sequences register-bus write strobes or
//               read requests with address auto-increment. Read data is
//               shifted back out MSB-first on sdo.
// Ports       : clk, reset      - system clock, synchronous active-high reset
//               sck, sdi, cs_n  - SPI lines, already synchronized to clk
//               sdo             - SPI data out (0 unless in a read phase)
//               reg_addr        - register bus address
//               reg_wdata       - register bus write data
//               reg_we, reg_re  - single-cycle write strobe / read request
//               reg_rdata       - read data, valid one clk after reg_re
//               busy            - frame in progress
// Revision    : 1.0 - initial release
// ============================================================================
module spi_register_controller #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  sdi,
    input  logic                  cs_n,
    output logic                  sdo,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CMD        = 2'd1,
        ST_WRITE_DATA = 2'd2,
        ST_READ_DATA  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  re_q, re_d;
    logic                  load_q, load_d;   // reg_rdata is valid this cycle
    logic                  busy_q, busy_d;
    logic                  sck_prev_q, sck_prev_d;

    logic                  w_rise;
    logic                  w_fall;
    logic [DATA_WIDTH-1:0] w_byte;           // rx contents including this bit

    assign w_rise = sck & ~sck_prev_q;
    assign w_fall = ~sck & sck_prev_q;
    assign w_byte = {rx_q[DATA_WIDTH-2:0], sdi};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        re_d       = 1'b0;
        load_d     = re_q;
        sck_prev_d = sck;

        // Post-increment follows the write strobe by one cycle; a strobe
        // that was already issued still completes if the frame just ended.
        if (we_q) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = 3'd0;
                rx_d  = '0;
                // An sck rise coincident with cs_n falling is not counted.
                if (!cs_n) begin
                    state_d = ST_CMD;
                end
            end
            default: begin
                if (cs_n) begin
                    // Frame aborted: partial byte dropped, no new strobe.
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                    rx_d    = '0;
                end else begin
                    if (state_q == ST_READ_DATA) begin
                        if (load_q) begin
                            tx_d = reg_rdata;
                        end else if (w_fall && (cnt_q != 3'd0)) begin
                            // The fall right after a byte boundary must not
                            // shift, so the next byte's MSB stays on sdo.
                            tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                    if (w_rise) begin
                        rx_d  = w_byte;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            case (state_q)
                                ST_CMD: begin
                                    addr_d = w_byte[ADDR_WIDTH-1:0];
                                    if (w_byte[DATA_WIDTH-1]) begin
                                        state_d = ST_WRITE_DATA;
                                    end else begin
                                        state_d = ST_READ_DATA;
                                        re_d    = 1'b1;
                                    end
                                end
                                ST_WRITE_DATA: begin
                                    wdata_d = w_byte;
                                    we_d    = 1'b1;
                                end
                                ST_READ_DATA: begin
                                    // Prefetch the next address; its data is
                                    // simply unused if the frame ends here.
                                    addr_d = addr_q + ADDR_WIDTH'(1);
                                    re_d   = 1'b1;
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            rx_q       <= '0;
            tx_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            load_q     <= 1'b0;
            busy_q     <= 1'b0;
            sck_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            re_q       <= re_d;
            load_q     <= load_d;
            busy_q     <= busy_d;
            sck_prev_q <= sck_prev_d;
        end
    end

    assign sdo       = (state_q == ST_READ_DATA) ? tx_q[DATA_WIDTH-1] : 1'b0;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = re_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_register_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_register_controller
// Description : Directed self-checking bench for spi_register_controller.
//               Drives SPI frames as a mode-0 master, models a register file
//               answering reg_re one clk later, and records bus strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_register_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       sck;
    logic       sdi;
    logic       cs_n;
    logic       sdo;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int overlap = 0;

    int we_addr[$];
    int we_data[$];
    int re_addr[$];

    logic [7:0] mem [128];

    spi_register_controller #(
        .ADDR_WIDTH (7),
        .DATA_WIDTH (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sck       (sck),
        .sdi       (sdi),
        .cs_n      (cs_n),
        .sdo       (sdo),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Register file model: data valid exactly one clk after reg_re, zero
    // otherwise so that mistimed capture shows up as wrong data.
    always @(posedge clk) begin
        reg_rdata <= reg_re ? mem[reg_addr] : 8'h00;
    end

    always @(negedge clk) begin
        if (reg_we) begin
            we_addr.push_back(int'(reg_addr));
            we_data.push_back(int'(reg_wdata));
        end
        if (reg_re) begin
            re_addr.push_back(int'(reg_addr));
        end
        if (reg_we && reg_re) begin
            overlap++;
        end
    end

    task automatic check_value(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int q_at(input int q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        we_addr.delete();
        we_data.delete();
        re_addr.delete();
    endtask

    // Master: sdo is sampled just before each rise, sdi changes while sck low.
    task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            sdi = b[7-i];
            tick(4);
            got = {got[6:0], sdo};
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [7:0] got);
        send_bits(b, 8, got);
    endtask

    task automatic end_frame();
        tick(4);
        cs_n = 1'b1;
        tick(6);
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] rd0;
        logic [7:0] rd1;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[7'h10] = 8'h3C;
        mem[7'h11] = 8'hC3;
        mem[7'h21] = 8'hFF;

        reset = 1'b1;
        sck   = 1'b0;
        sdi   = 1'b0;
        cs_n  = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        check_value("rst_sdo",   int'(sdo),       0);
        check_value("rst_addr",  int'(reg_addr),  0);
        check_value("rst_wdata", int'(reg_wdata), 0);
        check_value("rst_strb",  int'({reg_we, reg_re}), 0);
        check_value("rst_busy",  int'(busy),      0);

        // Single write
        clear_log();
        cs_n = 1'b0;
        tick(2);
        check_value("wr_busy", int'(busy), 1);
        send_byte(8'h85, got);
        send_byte(8'hA5, got);
        end_frame();
        check_value("wr_we_cnt", we_addr.size(), 1);
        check_value("wr_addr",   q_at(we_addr, 0), 'h05);
        check_value("wr_data",   q_at(we_data, 0), 'hA5);
        check_value("wr_re_cnt", re_addr.size(), 0);
        check_value("wr_incr",   int'(reg_addr), 'h06);
        check_value("wr_idle",   int'(busy), 0);

        // Burst write across the address wrap
        clear_log();
        cs_n = 1'b0;
        tick(2);
        send_byte(8'hFF, got);
        send_byte(8'h11, got);
        send_byte(8'h22, got);
        end_frame();
        check_value("wrap_cnt",   we_addr.size(), 2);
        check_value("wrap_addr0", q_at(we_addr, 0), 'h7F);
        check_value("wrap_data0", q_at(we_data, 0), 'h11);
        check_value("wrap_addr1", q_at(we_addr, 1), 'h00);
        check_value("wrap_data1", q_at(we_data, 1), 'h22);

        // Burst read with prefetch
        clear_log();
        cs_n = 1'b0;
        tick(2);
        send_byte(8'h10, got);
        check_value("rd_cmd_sdo", int'(got), 0);
        send_byte(8'h00, rd0);
        send_byte(8'h00, rd1);
        end_frame();
        check_value("rd_byte0",  int'(rd0), 'h3C);
        check_value("rd_byte1",  int'(rd1), 'hC3);
        check_value("rd_re_cnt", re_addr.size(), 3);
        check_value("rd_re0",    q_at(re_addr, 0), 'h10);
        check_value("rd_re1",    q_at(re_addr, 1), 'h11);
        check_value("rd_we_cnt", we_addr.size(), 0);
        check_value("rd_sdo_idle", int'(sdo), 0);

        // Aborted data byte, then a clean frame
        clear_log();
        cs_n = 1'b0;
        tick(2);
        send_byte(8'h85, got);
        send_bits(8'hF0, 4, got);
        cs_n = 1'b1;
        tick(1);
        check_value("abort_busy", int'(busy), 0);
        tick(5);
        check_value("abort_we", we_addr.size(), 0);
        cs_n = 1'b0;
        tick(2);
        send_byte(8'h83, got);
        send_byte(8'h5A, got);
        end_frame();
        check_value("post_abort_cnt",  we_addr.size(), 1);
        check_value("post_abort_addr", q_at(we_addr, 0), 'h03);
        check_value("post_abort_data", q_at(we_data, 0), 'h5A);

        // cs_n rising together with the 8th rise of a data byte
        clear_log();
        cs_n = 1'b0;
        tick(2);
        send_byte(8'h82, got);
        send_bits(8'h5A, 7, got);
        sdi = 1'b0;
        tick(4);
        sck  = 1'b1;
        cs_n = 1'b1;
        tick(4);
        sck = 1'b0;
        tick(6);
        check_value("coll_we",   we_addr.size(), 0);
        check_value("coll_addr", int'(reg_addr), 'h02);

        // Rise coincident with cs_n falling must not be counted
        clear_log();
        sck  = 1'b1;
        cs_n = 1'b0;
        tick(4);
        sck = 1'b0;
        send_byte(8'h84, got);
        send_byte(8'h77, got);
        end_frame();
        check_value("csfall_cnt",  we_addr.size(), 1);
        check_value("csfall_addr", q_at(we_addr, 0), 'h04);
        check_value("csfall_data", q_at(we_data, 0), 'h77);

        // Reset in the middle of the second read byte
        clear_log();
        cs_n = 1'b0;
        tick(2);
        send_byte(8'h20, got);
        send_byte(8'h00, got);
        send_bits(8'h00, 3, got);
        tick(2);
        check_value("pre_rst_sdo",  int'(sdo),  1);
        check_value("pre_rst_busy", int'(busy), 1);
        reset = 1'b1;
        tick(1);
        check_value("mid_rst_sdo",  int'(sdo),  0);
        check_value("mid_rst_strb", int'({reg_we, reg_re}), 0);
        check_value("mid_rst_busy", int'(busy), 0);
        check_value("mid_rst_addr", int'(reg_addr), 0);
        reset = 1'b0;
        cs_n  = 1'b1;
        tick(4);

        check_value("we_re_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_register_controller.md
Name: spi_register_controller

Overview:
- SPI mode-0 slave front end that sequences register accesses from the synchronized SPI lines (`sck`, `sdi`, `cs_n`, two-flop synchronized upstream) onto a simple internal register bus.
- Frames bytes, decodes a command byte, then issues write strobes or read requests with address auto-increment, and shifts read data back out on `sdo`.
- Sits between the SPI synchronizer and the device register file.

Parameters:
- ADDR_WIDTH, 7, register address width; equals command byte bits [6:0], fixed by protocol.
- DATA_WIDTH, 8, data byte width; fixed by protocol.

Ports:
- `clk` input 1 system clock; all logic on rising edge.
- `reset` input 1 synchronous, active-high reset.
- `sck` input 1 SPI clock, already synchronized to `clk`.
- `sdi` input 1 SPI data in, already synchronized.
- `cs_n` input 1 chip select, active-low, already synchronized.
- `sdo` output 1 SPI data out.
- `reg_addr` output 7 register bus address.
- `reg_wdata` output 8 register bus write data.
- `reg_we` output 1 one-cycle write strobe.
- `reg_re` output 1 one-cycle read request.
- `reg_rdata` input 8 read data, valid exactly 1 `clk` after `reg_re`.
- `busy` output 1 high while `cs_n` is low and a frame is in progress.

Behaviour:
- Reset: state IDLE; `sdo`, `reg_addr`, `reg_wdata`, `reg_we`, `reg_re`, `busy` all 0; bit counter 0; shift registers 0; `sck_prev` 0.
- Edge detect: `sck_prev` registered each cycle. rise = `sck` & ~`sck_prev`; fall = ~`sck` & `sck_prev`.
- States: IDLE, CMD, WRITE_DATA, READ_DATA.
- IDLE:
  - `sdo` = 0.
  - `cs_n` low -> CMD, bit counter 0, `busy` 1 from the next cycle.
- Bit counting:
  - In any non-IDLE state, each rise shifts `sdi` into the rx shift register MSB-first and increments the 3-bit counter.
  - On the 8th rise (counter 7 -> 0) the byte is complete; it is acted on in that same cycle.
- CMD byte complete:
  - `reg_addr` <= byte[6:0].
  - byte[7]=1 -> WRITE_DATA.
  - byte[7]=0 -> READ_DATA; `reg_re` pulses the next cycle with the new `reg_addr`.
  - `sdo` = 0 throughout CMD.
- WRITE_DATA byte complete:
  - `reg_wdata` <= byte; `reg_we` pulses 1 cycle later with the current `reg_addr`.
  - The cycle after `reg_we`, `reg_addr` increments mod 128 (0x7F wraps to 0x00).
- READ_DATA:
  - The cycle after `reg_re`, tx shift register <= `reg_rdata`.
  - `sdo` = tx[7] continuously.
  - On each fall with counter != 0, tx shifts left (zero fill). At counter == 0 a fall does not shift, so the new byte's MSB stays on `sdo`.
  - On each byte complete: `reg_addr` increments mod 128, then `reg_re` pulses for the next address (prefetch). Its data is unused if the frame ends.
- Timing requirement: `sck` half-period >= 4 `clk` cycles, so the prefetch load lands before the first fall of the next byte.
- `cs_n` high in any non-IDLE state:
  - -> IDLE next cycle; partial byte discarded; counter cleared; no strobe generated.
  - A strobe already scheduled for this cycle still completes.
- `cs_n` rising in the same cycle as the 8th rise: `cs_n` wins; the byte is discarded, no `reg_we`/`reg_re`.
- Rise and `cs_n` falling in the same cycle: the edge is ignored; the frame starts counting from the next rise.
- `reset` mid-frame: immediate return to reset values; any pending strobe is cancelled.
- `reg_we` and `reg_re` are never high in the same cycle; each is high at most 1 cycle per byte.

Test Plan:
- Write frame: `cs_n` low, send 0x85, 0xA5 -> exactly one `reg_we` with `reg_addr`=0x05, `reg_wdata`=0xA5; no `reg_re`.
- Burst write wrap: send 0xFF, 0x11, 0x22 -> `reg_we` at addr 0x7F data 0x11, then addr 0x00 data 0x22.
- Read: send 0x10 with the bus returning 0x3C at addr 0x10 and 0xC3 at addr 0x11 -> `reg_re` at 0x10; `sdo` bits sampled on rises for the next two bytes are 0x3C then 0xC3.
- Aborted byte: send 0x85, 4 data bits, `cs_n` high -> no `reg_we`; `busy` 0 one cycle later; the next frame decodes correctly.
- Boundary collision: raise `cs_n` in the same `clk` cycle as the 8th rise of a write data byte -> no `reg_we`.
- Reset mid-read: assert `reset` during the second read byte -> `sdo`, strobes and `busy` read 0 the next cycle; `reg_addr`=0.
